dac_spi_out: RTL and testbench

//  Output stage downstream of the eight-channel summing block. Captures the signed
//  16-bit summed sample on each sample-rate strobe and converts it to offset binary.

---
 rtl/wavegen_pkg.sv | 19 +
 rtl/spi_half_tick.sv | 29 ++
 rtl/dac_spi_out.sv | 154 +++++++++++++++
 tb/tb_dac_spi_out.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavegen_pkg.sv
// Shared definitions for the waveform output path: sample width, DAC-frame FSM
// state encoding and the two's-complement to offset-binary conversion.
package wavegen_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SETUP = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t HOLD  = 2'd3;

  // Offset binary is two's complement with the sign bit flipped.
  function automatic logic [SAMPLE_W-1:0] to_offset_bin(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Divides clk down to one strobe every CLK_DIV cycles, marking the last cycle of
// each SCLK half-period. Restarted at frame start so phases align to the frame.
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_tick
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (half_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign half_tick = (cnt_q == LAST);

endmodule

// File: rtl/dac_spi_out.sv
// Captures summed samples on the sample-rate strobe and ships them, with a command
// prefix, to an SPI mode-0 DAC. Newest sample wins; overwritten samples are flagged.
module dac_spi_out
  import wavegen_pkg::*;
#(
  parameter int               SAMPLE_W = 16,
  parameter int               CMD_W    = 8,
  parameter logic [CMD_W-1:0] DAC_CMD  = 8'h30,
  parameter int               CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                dac_sclk,
  output logic                dac_mosi,
  output logic                dac_cs_n,
  output logic                busy,
  output logic                overrun
);

  localparam int FRAME_W = CMD_W + SAMPLE_W;
  localparam int BW      = $clog2(FRAME_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);

  state_t               state_q, state_d;
  logic                 load;
  logic                 half_tick;
  logic                 last_fall;
  logic [FRAME_W-1:0]   frame_word;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [SAMPLE_W-1:0]  hold_q;
  logic                 pending_q;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk       (clk),
    .reset     (reset),
    .clear     (load),
    .half_tick (half_tick)
  );

  // A tick on the load cycle goes straight into the frame, bypassing hold_q.
  assign frame_word = {DAC_CMD, sample_tick ? to_offset_bin(sample) : hold_q};
  assign last_fall  = (state_q == SHIFT) && half_tick && sclk_q && (bit_q == LAST_BIT);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q || sample_tick) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        if (half_tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_fall) state_d = HOLD;
      end
      HOLD: begin
        if (half_tick) begin
          if (pending_q || sample_tick) begin
            state_d = SETUP;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // mosi only moves on falling sclk, so it is stable across each rising edge.
  always_comb begin
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    if (load) begin
      shreg_d = frame_word;
      mosi_d  = frame_word[FRAME_W-1];
      sclk_d  = 1'b0;
      bit_d   = '0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (half_tick) begin
            if (!sclk_q) begin
              sclk_d = 1'b1;
            end else begin
              sclk_d = 1'b0;
              if (last_fall) begin
                mosi_d = 1'b0;
              end else begin
                shreg_d = shreg_q << 1;
                mosi_d  = shreg_q[FRAME_W-2];
                bit_d   = bit_q + BW'(1);
              end
            end
          end
        end
        SETUP: ;
        default: begin
          sclk_d = 1'b0;
          mosi_d = 1'b0;
        end
      endcase
    end
    cs_n_d = !((state_d == SETUP) || (state_d == SHIFT));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_q     <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      if (sample_tick) hold_q <= to_offset_bin(sample);
      pending_q <= !load && (sample_tick || pending_q);
      overrun_q <= sample_tick && pending_q && !load;
    end
  end

  assign dac_sclk = sclk_q;
  assign dac_mosi = mosi_q;
  assign dac_cs_n = cs_n_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_dac_spi_out.sv
// Directed bench for dac_spi_out at CLK_DIV=2: a frame monitor reconstructs each
// SPI word from rising sclk, and expected words come from hand-computed tables.
module tb_dac_spi_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic [15:0] sample;
  logic        dac_sclk, dac_mosi, dac_cs_n, busy, overrun;

  typedef struct {
    logic [15:0] sample;
    logic [23:0] word;
  } vec_t;

  typedef struct {
    logic [23:0] word;
    int          rises;
    int          low;
    int          err;
  } frame_t;

  vec_t        vecs[6];
  frame_t      frame_q[$];
  int          busy_runs[$];
  logic [23:0] exp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int overrun_cnt = 0;

  dac_spi_out #(.CLK_DIV(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .sample      (sample),
    .dac_sclk    (dac_sclk),
    .dac_mosi    (dac_mosi),
    .dac_cs_n    (dac_cs_n),
    .busy        (busy),
    .overrun     (overrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // frame monitor, sampled on the falling edge
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  frame_t      cur;
  int          busy_run = 0;

  always @(negedge clk) begin
    if (dac_cs_n === 1'b0) begin
      if (prev_cs) begin
        cur.word = '0; cur.rises = 0; cur.low = 0; cur.err = 0;
      end
      cur.low++;
      if (dac_sclk && !prev_sclk) begin
        cur.word = {cur.word[22:0], dac_mosi};
        cur.rises++;
      end
      if (!prev_cs && (dac_mosi != prev_mosi) && !(prev_sclk && !dac_sclk)) cur.err++;
    end else if (!prev_cs) begin
      frame_q.push_back(cur);
    end
    if (busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      busy_runs.push_back(busy_run);
      busy_run = 0;
    end
    if (overrun === 1'b1) overrun_cnt++;
    prev_cs   = (dac_cs_n !== 1'b0);
    prev_sclk = (dac_sclk === 1'b1);
    prev_mosi = (dac_mosi === 1'b1);
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick(input logic [15:0] s);
    @(posedge clk);
    #1 sample = s;
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1; break; end
    end
    if (!ok) check({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic check_frame(input string name, input int exp_low);
    frame_t      f;
    logic [23:0] exp_word;
    bit          ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (frame_q.size() > 0) begin f = frame_q.pop_front(); ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check({name, "_frame_timeout"}, 0, 1);
    end else begin
      exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      check({name, "_word"}, 32'(f.word), 32'(exp_word));
      check({name, "_sclk_rises"}, f.rises, 24);
      check({name, "_cs_low_cycles"}, f.low, exp_low);
      check({name, "_mosi_only_on_fall"}, f.err, 0);
    end
  endtask

  task automatic check_busy(input string name, input int exp_run);
    bit ok = 0;
    int run = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy_runs.size() > 0) begin run = busy_runs.pop_front(); ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check({name, "_busy_timeout"}, 0, 1);
    else check({name, "_busy_cycles"}, run, exp_run);
  endtask

  // stimulus and scoreboard
  initial begin
    frame_t pf;

    vecs[0] = '{16'h0000, 24'h308000};
    vecs[1] = '{16'h8000, 24'h300000};
    vecs[2] = '{16'h7FFF, 24'h30FFFF};
    vecs[3] = '{16'h1234, 24'h309234};
    vecs[4] = '{16'hFFFF, 24'h307FFF};
    vecs[5] = '{16'h0001, 24'h308001};

    reset = 1'b1;
    sample_tick = 1'b0;
    sample = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cs_n", dac_cs_n, 1);
    check("reset_sclk", dac_sclk, 0);
    check("reset_mosi", dac_mosi, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    frame_q.delete();
    busy_runs.delete();
    @(posedge clk);
    #1 reset = 1'b0;

    // single frames from an idle FSM
    for (int i = 0; i < 6; i++) begin
      wait_idle($sformatf("vec%0d", i));
      exp_q.push_back(vecs[i].word);
      tick(vecs[i].sample);
      @(negedge clk);
      check($sformatf("vec%0d_latency_cs_n", i), dac_cs_n, 0);
      check($sformatf("vec%0d_latency_busy", i), busy, 1);
      check_frame($sformatf("vec%0d", i), 98);
      check_busy($sformatf("vec%0d", i), 100);
    end
    check("table_no_overrun", overrun_cnt, 0);

    // two ticks inside one frame: second overwrites the pending first
    wait_idle("ovr");
    overrun_cnt = 0;
    exp_q.push_back(24'h30C000);
    exp_q.push_back(24'h308100);
    tick(16'h4000);
    repeat (20) @(posedge clk);
    tick(16'h1234);
    @(negedge clk);
    check("ovr_first_tick_quiet", overrun, 0);
    repeat (20) @(posedge clk);
    tick(16'h0100);
    @(negedge clk);
    check("ovr_pulse", overrun, 1);
    @(negedge clk);
    check("ovr_pulse_one_cycle", overrun, 0);
    check_frame("ovr_f1", 98);
    check_frame("ovr_f2", 98);
    check_busy("ovr_back_to_back", 200);
    check("ovr_count", overrun_cnt, 1);

    // tick on the last HOLD cycle chains straight into SETUP
    wait_idle("hold");
    overrun_cnt = 0;
    exp_q.push_back(24'h308002);
    exp_q.push_back(24'h308001);
    tick(16'h0002);
    repeat (98) @(posedge clk);
    @(posedge clk);
    #1 sample = 16'h0001;
    sample_tick = 1'b1;
    @(negedge clk);
    check("hold_last_cycle_cs_n", dac_cs_n, 1);
    check("hold_last_cycle_busy", busy, 1);
    @(posedge clk);
    #1 sample_tick = 1'b0;
    @(negedge clk);
    check("hold_next_cs_fall", dac_cs_n, 0);
    check_frame("hold_f1", 98);
    check_frame("hold_f2", 98);
    check_busy("hold_back_to_back", 200);
    check("hold_no_overrun", overrun_cnt, 0);

    // reset during bit 10 of SHIFT aborts the frame with no tail
    wait_idle("rst");
    tick(16'h5555);
    repeat (42) @(posedge clk);
    @(negedge clk);
    check("rst_mid_frame_cs_n", dac_cs_n, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_abort_cs_n", dac_cs_n, 1);
    check("rst_abort_sclk", dac_sclk, 0);
    check("rst_abort_mosi", dac_mosi, 0);
    check("rst_abort_busy", busy, 0);
    @(negedge clk);
    if (frame_q.size() > 0) begin
      pf = frame_q.pop_front();
      check("rst_partial_rises", pf.rises, 10);
      check("rst_partial_low", pf.low, 44);
    end else begin
      check("rst_partial_frame_seen", 0, 1);
    end
    repeat (10) @(negedge clk);
    check("rst_stays_idle", {frame_q.size() == 0, busy, dac_cs_n}, 3'b101);
    frame_q.delete();
    busy_runs.delete();
    exp_q.push_back(24'h3080FF);
    tick(16'h00FF);
    check_frame("rst_after", 98);
    check_busy("rst_after", 100);

    // tick held during reset is ignored
    wait_idle("rsttick");
    busy_runs.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    sample = 16'h7777;
    sample_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sample_tick = 1'b0;
    repeat (20) @(negedge clk);
    check("rsttick_no_frame", frame_q.size(), 0);
    check("rsttick_no_busy", busy_runs.size() + int'(busy === 1'b1), 0);
    check("rsttick_cs_n", dac_cs_n, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
